// File: rtl/video_sprite_motion_ctrl_if.sv
// Avalon-MM write-only link between the sprite motion controller and the sprite core.
interface video_sprite_motion_ctrl_if #(
  parameter int AVM_AW = 13
);
  logic              avm_write;
  logic [AVM_AW-1:0] avm_address;
  logic [31:0]       avm_writedata;
  logic              avm_waitrequest;

  modport master (
    output avm_write,
    output avm_address,
    output avm_writedata,
    input  avm_waitrequest
  );

  modport slave (
    input  avm_write,
    input  avm_address,
    input  avm_writedata,
    output avm_waitrequest
  );
endinterface

// File: rtl/video_sprite_motion_ctrl.sv
// Bounces a sprite origin around the screen once per frame and pushes x/y to the sprite core.
// Optional `SPRITE_MOTION_CTRL_INIT_EN adds a post-reset write of 0 to the core's ctrl register.
module video_sprite_motion_ctrl #(
  parameter int H_DISPLAY    = 640,
  parameter int V_DISPLAY    = 480,
  parameter int SPRITE_HSIZE = 32,
  parameter int SPRITE_VSIZE = 32,
  parameter int X_INIT       = 0,
  parameter int Y_INIT       = 0,
  parameter int X_STEP       = 2,
  parameter int Y_STEP       = 2,
  parameter int AVM_AW       = 13
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enable,
  input  logic                        frame_start,
  video_sprite_motion_ctrl_if.master  avm,
  output logic                        busy,
  output logic [15:0]                 x_pos,
  output logic [15:0]                 y_pos
);

  localparam logic [15:0] XMAX = 16'(H_DISPLAY - SPRITE_HSIZE);
  localparam logic [15:0] YMAX = 16'(V_DISPLAY - SPRITE_VSIZE);
  localparam logic [15:0] XSTEP = 16'(X_STEP);
  localparam logic [15:0] YSTEP = 16'(Y_STEP);
  localparam logic [AVM_AW-1:0] ADDR_X = AVM_AW'(4);
  localparam logic [AVM_AW-1:0] ADDR_Y = AVM_AW'(8);

`ifdef SPRITE_MOTION_CTRL_INIT_EN
  typedef enum logic [2:0] {INIT, IDLE, CALC, WR_X, WR_Y} state_t;
  localparam state_t RESET_STATE = INIT;
`else
  typedef enum logic [2:0] {IDLE, CALC, WR_X, WR_Y} state_t;
  localparam state_t RESET_STATE = IDLE;
`endif

  state_t      state;
  logic        dir_x;
  logic        dir_y;
  logic [15:0] x_next;
  logic [15:0] y_next;
  logic        dir_x_next;
  logic        dir_y_next;
  logic [16:0] x_sum;
  logic [16:0] y_sum;

  assign x_sum = {1'b0, x_pos} + {1'b0, XSTEP};
  assign y_sum = {1'b0, y_pos} + {1'b0, YSTEP};

  // Direction bit 0 means moving towards larger coordinates; edges clamp rather than wrap.
  always_comb begin
    x_next     = x_pos;
    dir_x_next = dir_x;
    if (!dir_x) begin
      if (x_sum >= {1'b0, XMAX}) begin
        x_next     = XMAX;
        dir_x_next = 1'b1;
      end else begin
        x_next = x_sum[15:0];
      end
    end else if (x_pos <= XSTEP) begin
      x_next     = '0;
      dir_x_next = 1'b0;
    end else begin
      x_next = x_pos - XSTEP;
    end
  end

  always_comb begin
    y_next     = y_pos;
    dir_y_next = dir_y;
    if (!dir_y) begin
      if (y_sum >= {1'b0, YMAX}) begin
        y_next     = YMAX;
        dir_y_next = 1'b1;
      end else begin
        y_next = y_sum[15:0];
      end
    end else if (y_pos <= YSTEP) begin
      y_next     = '0;
      dir_y_next = 1'b0;
    end else begin
      y_next = y_pos - YSTEP;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= RESET_STATE;
      busy              <= 1'b0;
      avm.avm_write     <= 1'b0;
      avm.avm_address   <= '0;
      avm.avm_writedata <= '0;
      x_pos             <= 16'(X_INIT);
      y_pos             <= 16'(Y_INIT);
      dir_x             <= 1'b0;
      dir_y             <= 1'b0;
    end else begin
      case (state)
`ifdef SPRITE_MOTION_CTRL_INIT_EN
        // Address and data are already zero from reset; only the strobe needs raising.
        INIT: begin
          if (!avm.avm_write) begin
            avm.avm_write     <= 1'b1;
            avm.avm_address   <= '0;
            avm.avm_writedata <= '0;
            busy              <= 1'b1;
          end else if (!avm.avm_waitrequest) begin
            avm.avm_write <= 1'b0;
            busy          <= 1'b0;
            state         <= IDLE;
          end
        end
`endif
        IDLE: begin
          if (frame_start && enable) begin
            busy  <= 1'b1;
            state <= CALC;
          end
        end
        CALC: begin
          x_pos             <= x_next;
          y_pos             <= y_next;
          dir_x             <= dir_x_next;
          dir_y             <= dir_y_next;
          avm.avm_write     <= 1'b1;
          avm.avm_address   <= ADDR_X;
          avm.avm_writedata <= {16'b0, x_next};
          state             <= WR_X;
        end
        WR_X: begin
          if (!avm.avm_waitrequest) begin
            avm.avm_address   <= ADDR_Y;
            avm.avm_writedata <= {16'b0, y_pos};
            state             <= WR_Y;
          end
        end
        WR_Y: begin
          if (!avm.avm_waitrequest) begin
            avm.avm_write <= 1'b0;
            busy          <= 1'b0;
            state         <= IDLE;
          end
        end
        default: begin
          avm.avm_write <= 1'b0;
          busy          <= 1'b0;
          state         <= IDLE;
        end
      endcase
    end
  end

endmodule
